program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 126 ++++++++++++
 tb/tb_program_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Program loader: receives a length-prefixed, checksummed byte stream,
// writes the payload into program memory starting at BASE_ADDR, and
// releases the processor only when the checksum matches.
module program_loader #(
   parameter logic [7:0] BASE_ADDR = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_din,
   output logic       mem_we,
   output logic       cpu_run,
   output logic       busy,
   output logic       done,
   output logic       error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_CHK,
      S_RUN,
      S_ERR
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [8:0] remaining;   // data bytes still expected; 9 bits so N=0 can mean 256
   logic [7:0] sum;         // running mod-256 sum of the data bytes
   logic [7:0] wr_ptr;      // address the next data byte will be written to
   logic       accept;

   assign accept = in_valid & in_ready;

   // State register; reset returns to IDLE immediately, independent of clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         // NOTE: registers use non-blocking (<=) so every flop samples the
         // pre-edge values; blocking (=) here would create ordering races.
         state <= state_nxt;
      end
   end

   // Next-state decode and state-derived status outputs.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case leaves a signal unassigned and infers a latch.
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      cpu_run   = 1'b0;
      done      = 1'b0;
      error     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_HDR;
         end
         S_HDR: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) state_nxt = S_DATA;
         end
         S_DATA: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid && (remaining == 9'd1)) state_nxt = S_CHK;
         end
         S_CHK: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) state_nxt = (in_data == sum) ? S_RUN : S_ERR;
         end
         S_RUN: begin
            cpu_run = 1'b1;
            done    = 1'b1;
            if (start) state_nxt = S_HDR;
         end
         S_ERR: begin
            error = 1'b1;
            if (start) state_nxt = S_HDR;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath: length capture, memory write port, pointer and checksum.
   // mem_we is a one-cycle pulse following each accepted data byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining <= 9'd0;
         sum       <= 8'h00;
         wr_ptr    <= 8'h00;
         mem_addr  <= 8'h00;
         mem_din   <= 8'h00;
         mem_we    <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         if (accept) begin
            case (state)
               S_HDR: begin
                  remaining <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                  sum       <= 8'h00;
                  wr_ptr    <= BASE_ADDR;
               end
               S_DATA: begin
                  mem_addr  <= wr_ptr;
                  mem_din   <= in_data;
                  mem_we    <= 1'b1;
                  wr_ptr    <= wr_ptr + 8'd1;
                  sum       <= sum + in_data;
                  remaining <= remaining - 9'd1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a cycle table for good load, restart and bad
// checksum, then directed sequences for stalls, mid-load reset and the
// 256-byte wrapping load on an instance based at 8'hFE.
module tb_program_loader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       in_valid;
   logic [7:0] in_data;

   logic       ready_a, we_a, run_a, busy_a, done_a, err_a;
   logic [7:0] addr_a, din_a;
   logic       ready_b, we_b, run_b, busy_b, done_b, err_b;
   logic [7:0] addr_b, din_b;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] addr_qa[$];
   logic [7:0] din_qa[$];
   logic [7:0] addr_qb[$];
   logic [7:0] din_qb[$];

   always #5 clk = ~clk;

   program_loader #(.BASE_ADDR(8'h00)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(ready_a), .mem_addr(addr_a), .mem_din(din_a), .mem_we(we_a),
      .cpu_run(run_a), .busy(busy_a), .done(done_a), .error(err_a)
   );

   program_loader #(.BASE_ADDR(8'hFE)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(ready_b), .mem_addr(addr_b), .mem_din(din_b), .mem_we(we_b),
      .cpu_run(run_b), .busy(busy_b), .done(done_b), .error(err_b)
   );

   // Record every write pulse; mem_we is stable across the negedge.
   always @(negedge clk) begin
      if (we_a) begin
         addr_qa.push_back(addr_a);
         din_qa.push_back(din_a);
      end
      if (we_b) begin
         addr_qb.push_back(addr_b);
         din_qb.push_back(din_b);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the negedge, return just after the posedge.
   task automatic step(input logic s, input logic v, input logic [7:0] d);
      @(negedge clk);
      start    = s;
      in_valid = v;
      in_data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check_a(input string tag, input logic rdy, input logic we,
                          input logic [7:0] addr, input logic [7:0] din,
                          input logic bsy, input logic run, input logic dn,
                          input logic er);
      check({tag, ".in_ready"}, ready_a, rdy);
      check({tag, ".mem_we"},   we_a,    we);
      check({tag, ".mem_addr"}, addr_a,  addr);
      check({tag, ".mem_din"},  din_a,   din);
      check({tag, ".busy"},     busy_a,  bsy);
      check({tag, ".cpu_run"},  run_a,   run);
      check({tag, ".done"},     done_a,  dn);
      check({tag, ".error"},    err_a,   er);
   endtask

   task automatic clear_q();
      addr_qa.delete();
      din_qa.delete();
      addr_qb.delete();
      din_qb.delete();
   endtask

   typedef struct {
      logic       s;
      logic       v;
      logic [7:0] d;
      logic       rdy;
      logic       we;
      logic [7:0] addr;
      logic [7:0] din;
      logic       bsy;
      logic       run;
      logic       dn;
      logic       er;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int bad;

      // Expected state of dut_a just after each edge.
      //            s  v  d      rdy we addr   din    bsy run dn er
      vecs[0]  = '{1, 0, 8'h00,  1, 0, 8'h00, 8'h00, 1, 0, 0, 0};  // -> HDR
      vecs[1]  = '{0, 1, 8'h03,  1, 0, 8'h00, 8'h00, 1, 0, 0, 0};  // length 3
      vecs[2]  = '{0, 1, 8'hA1,  1, 1, 8'h00, 8'hA1, 1, 0, 0, 0};
      vecs[3]  = '{0, 1, 8'hB2,  1, 1, 8'h01, 8'hB2, 1, 0, 0, 0};
      vecs[4]  = '{0, 1, 8'hC3,  1, 1, 8'h02, 8'hC3, 1, 0, 0, 0};  // -> CHK
      vecs[5]  = '{0, 1, 8'h16,  0, 0, 8'h02, 8'hC3, 0, 1, 1, 0};  // -> RUN
      vecs[6]  = '{0, 0, 8'h00,  0, 0, 8'h02, 8'hC3, 0, 1, 1, 0};  // holds RUN
      vecs[7]  = '{1, 0, 8'h00,  1, 0, 8'h02, 8'hC3, 1, 0, 0, 0};  // restart
      vecs[8]  = '{0, 1, 8'h02,  1, 0, 8'h02, 8'hC3, 1, 0, 0, 0};
      vecs[9]  = '{0, 1, 8'h10,  1, 1, 8'h00, 8'h10, 1, 0, 0, 0};
      vecs[10] = '{0, 1, 8'h20,  1, 1, 8'h01, 8'h20, 1, 0, 0, 0};
      vecs[11] = '{0, 1, 8'h31,  0, 0, 8'h01, 8'h20, 0, 0, 0, 1};  // sum 30 -> ERR

      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      #12;
      check_a("reset", 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 1, 8'h55);
      step(0, 1, 8'h55);
      check_a("idle_wait", 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);

      // Good load, restart from RUN, bad checksum.
      clear_q();
      for (int i = 0; i < 12; i++) begin
         step(vecs[i].s, vecs[i].v, vecs[i].d);
         check_a($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].we, vecs[i].addr,
                 vecs[i].din, vecs[i].bsy, vecs[i].run, vecs[i].dn, vecs[i].er);
      end
      check("table.write_count", addr_qa.size(), 5);

      // Stalls in DATA and start pulses during the load, from ERR.
      clear_q();
      step(1, 0, 8'h00);
      check("stall.restart_busy", busy_a, 1);
      check("stall.restart_err", err_a, 0);
      step(0, 1, 8'h04);
      step(1, 1, 8'h01);
      check_a("stall.b1", 1, 1, 8'h00, 8'h01, 1, 0, 0, 0);
      step(0, 0, 8'hEE);
      check_a("stall.gap1", 1, 0, 8'h00, 8'h01, 1, 0, 0, 0);
      step(1, 0, 8'hEE);
      check_a("stall.gap2", 1, 0, 8'h00, 8'h01, 1, 0, 0, 0);
      step(0, 1, 8'h02);
      check_a("stall.b2", 1, 1, 8'h01, 8'h02, 1, 0, 0, 0);
      step(0, 1, 8'h03);
      step(0, 1, 8'h04);
      check_a("stall.b4", 1, 1, 8'h03, 8'h04, 1, 0, 0, 0);
      step(1, 1, 8'h0A);
      check_a("stall.run", 0, 0, 8'h03, 8'h04, 0, 1, 1, 0);
      check("stall.write_count", addr_qa.size(), 4);
      bad = 0;
      for (int i = 0; i < addr_qa.size(); i++)
         if (addr_qa[i] !== 8'(i) || din_qa[i] !== 8'(i + 1)) bad++;
      check("stall.contiguous", bad, 0);

      // Asynchronous reset in the middle of DATA, then a clean reload.
      step(1, 0, 8'h00);
      check("rst.run_drop", run_a, 0);
      step(0, 1, 8'h04);
      step(0, 1, 8'h11);
      step(0, 1, 8'h22);
      check_a("rst.pre", 1, 1, 8'h01, 8'h22, 1, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      check_a("rst.async", 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step(0, 1, 8'h77);
      check_a("rst.idle", 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
      clear_q();
      step(1, 0, 8'h00);
      step(0, 1, 8'h04);
      step(0, 1, 8'h11);
      step(0, 1, 8'h22);
      step(0, 1, 8'h33);
      step(0, 1, 8'h44);
      step(0, 1, 8'hAA);
      check_a("rst.reload_run", 0, 0, 8'h03, 8'h44, 0, 1, 1, 0);
      check("rst.write_count", addr_qa.size(), 4);
      bad = 0;
      for (int i = 0; i < addr_qa.size(); i++)
         if (addr_qa[i] !== 8'(i) || din_qa[i] !== 8'(8'h11 * (i + 1))) bad++;
      check("rst.contiguous", bad, 0);

      // Maximum length with pointer wrap on the FE-based instance.
      clear_q();
      step(1, 0, 8'h00);
      step(0, 1, 8'h00);
      for (int i = 0; i < 256; i++) begin
         step(0, 1, 8'h01);
         if (i < 255) check_a("wrap.nochk", 1, 1, 8'(i), 8'h01, 1, 0, 0, 0);
      end
      step(0, 1, 8'h00);
      check("wrap.run_b", run_b, 1);
      check("wrap.done_b", done_b, 1);
      check("wrap.err_b", err_b, 0);
      check("wrap.busy_b", busy_b, 0);
      check("wrap.count_b", addr_qb.size(), 256);
      check("wrap.first_b", addr_qb[0], 8'hFE);
      check("wrap.second_b", addr_qb[1], 8'hFF);
      check("wrap.third_b", addr_qb[2], 8'h00);
      check("wrap.last_b", addr_qb[255], 8'hFD);
      bad = 0;
      for (int i = 0; i < addr_qb.size(); i++)
         if (addr_qb[i] !== 8'(8'hFE + i) || din_qb[i] !== 8'h01) bad++;
      check("wrap.contiguous_b", bad, 0);
      step(0, 0, 8'h00);
      check("wrap.we_idle_b", we_b, 0);
      check("wrap.run_a", run_a, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
